// File: rtl/ahb_gpio_slave_pkg.sv
// Shared AHB encodings, GPIO register offsets and data-phase types for ahb_gpio_slave.
// No ports: imported by the interface, the synchronizer and the top.
package ahb_gpio_slave_pkg;

  localparam int unsigned AHB_AW = 32;
  localparam int unsigned AHB_DW = 32;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [3:0] HSIZE_8  = 4'd0;
  localparam logic [3:0] HSIZE_16 = 4'd1;
  localparam logic [3:0] HSIZE_32 = 4'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [3:0] GPIO_OFS_DOUT = 4'h0;
  localparam logic [3:0] GPIO_OFS_DIR  = 4'h4;
  localparam logic [3:0] GPIO_OFS_DIN  = 4'h8;
  localparam logic [3:0] GPIO_OFS_IRQ  = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic [3:0] ofs;
    logic       write;
    logic       err;
  } aphase_t;

  // Misaligned, non-word or write-to-DATA_IN accesses are answered with ERROR
  function automatic aphase_t decode_aphase(input logic [3:0] ofs, input logic write,
                                            input logic [3:0] size);
    aphase_t a;
    a.ofs   = ofs;
    a.write = write;
    a.err   = (ofs[1:0] != 2'b00) || (size != HSIZE_32) || (write && (ofs == GPIO_OFS_DIN));
    return a;
  endfunction

endpackage

// File: rtl/ahb_gpio_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_gpio_slave.
// slave modport: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in, HREADYOUT/HRESP/HRDATA out.
interface ahb_gpio_slave_if;
  import ahb_gpio_slave_pkg::*;

  logic              HSEL;
  logic [AHB_AW-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [3:0]        HSIZE;
  logic [AHB_DW-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [1:0]        HRESP;
  logic [AHB_DW-1:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_gpio_slave_gpio_in_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs plus rising-edge pulse vector.
// Ports: HCLK, HRESET, gpio_in (async pins), data_in_nxt_c (value the synchronized
// DATA_IN takes at the next edge), rise_c (one-cycle pulse per rising synchronized bit).
module gpio_in_sync
  import ahb_gpio_slave_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] data_in_nxt_c,
  output logic [GPIO_WIDTH-1:0] rise_c
);

  logic [GPIO_WIDTH-1:0] meta_q;
  logic [GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] prev_q;

  // Synchronizer chain and edge-detect history
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= gpio_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // The register bank presents read data registered, so it needs the upcoming value
  assign data_in_nxt_c = meta_q;
  assign rise_c        = sync_q & ~prev_q;

endmodule

// File: rtl/ahb_gpio_slave.sv
// AHB-Lite GPIO slave: DATA_OUT/DIR/DATA_IN/IRQ_STATUS bank with pipelined data phase,
// configurable wait states and two-cycle ERROR responses.
// Ports: HCLK, HRESET (async, active-high), bus (AHB slave modport),
// gpio_in (async pins), gpio_out, gpio_oe, irq (OR of IRQ_STATUS).
module ahb_gpio_slave
  import ahb_gpio_slave_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  ahb_gpio_slave_if.slave        bus,
  input  logic [GPIO_WIDTH-1:0]  gpio_in,
  output logic [GPIO_WIDTH-1:0]  gpio_out,
  output logic [GPIO_WIDTH-1:0]  gpio_oe,
  output logic                   irq
);

  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  aphase_t               aph_q, aph_d;
  logic [GPIO_WIDTH-1:0] irqst_q, irqst_d;
  logic [GPIO_WIDTH-1:0] dout_d, dir_d;
  logic [GPIO_WIDTH-1:0] din_nxt_c, rise_c;
  logic [GPIO_WIDTH-1:0] wdata_c;
  logic                  accept_c;
  logic                  hreadyout_d;
  logic [1:0]            hresp_d;
  logic [AHB_DW-1:0]     hrdata_d;
  logic                  unused_bits_c;

  assign accept_c      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign wdata_c       = GPIO_WIDTH'(bus.HWDATA);
  assign unused_bits_c = ^{bus.HADDR[AHB_AW-1:4], bus.HTRANS[0]};

  gpio_in_sync #(.GPIO_WIDTH(GPIO_WIDTH)) u_gpio_in_sync (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .gpio_in       (gpio_in),
    .data_in_nxt_c (din_nxt_c),
    .rise_c        (rise_c)
  );

  // Data-phase FSM, register-bank next values and next bus outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aph_d    = aph_q;
    dout_d   = gpio_out;
    dir_d    = gpio_oe;
    irqst_d  = irqst_q;
    hrdata_d = '0;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_LAST;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // Writes commit on the edge that ends S_LAST
    if (state_q == S_LAST && aph_q.write) begin
      case (aph_q.ofs)
        GPIO_OFS_DOUT: dout_d  = wdata_c;
        GPIO_OFS_DIR:  dir_d   = wdata_c;
        GPIO_OFS_IRQ:  irqst_d = irqst_q & ~wdata_c;
        default: ;
      endcase
    end
    // Applied after the W1C so a coincident edge keeps its bit set
    irqst_d = irqst_d | rise_c;

    if (accept_c && (state_q inside {S_IDLE, S_LAST, S_ERR2})) begin
      aph_d = decode_aphase(bus.HADDR[3:0], bus.HWRITE, bus.HSIZE);
      cnt_d = WAIT_LOAD;
      if (aph_d.err)            state_d = S_ERR1;
      else if (WAIT_STATES > 0) state_d = S_WAIT;
      else                      state_d = S_LAST;
    end

    hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d     = (state_d inside {S_ERR1, S_ERR2}) ? HRESP_ERROR : HRESP_OKAY;

    // Read data reflects register contents during the S_LAST cycle
    if (state_d == S_LAST && !aph_d.write) begin
      case (aph_d.ofs)
        GPIO_OFS_DOUT: hrdata_d = AHB_DW'(dout_d);
        GPIO_OFS_DIR:  hrdata_d = AHB_DW'(dir_d);
        GPIO_OFS_DIN:  hrdata_d = AHB_DW'(din_nxt_c);
        GPIO_OFS_IRQ:  hrdata_d = AHB_DW'(irqst_d);
        default:       hrdata_d = '0;
      endcase
    end
  end

  // State, register bank and registered bus outputs
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      aph_q         <= '0;
      gpio_out      <= '0;
      gpio_oe       <= '0;
      irqst_q       <= '0;
      irq           <= 1'b0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= HRESP_OKAY;
      bus.HRDATA    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aph_q         <= aph_d;
      gpio_out      <= dout_d;
      gpio_oe       <= dir_d;
      irqst_q       <= irqst_d;
      irq           <= |irqst_d;
      bus.HREADYOUT <= hreadyout_d;
      bus.HRESP     <= hresp_d;
      bus.HRDATA    <= hrdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Directed self-checking bench for ahb_gpio_slave: one instance with no wait states,
// one with two, sharing the master-side stimulus; only the selected one sees HSEL.
module tb_ahb_gpio_slave;
  import ahb_gpio_slave_pkg::*;

  localparam int unsigned GW  = 16;
  localparam int          LIM = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          use2 = 1'b0;
  logic          hsel = 1'b0;
  logic [31:0]   haddr = '0;
  logic [1:0]    htrans = TRANS_IDLE;
  logic          hwrite = 1'b0;
  logic [3:0]    hsize = HSIZE_32;
  logic [31:0]   hwdata = '0;
  logic [GW-1:0] gin0 = '0, gin2 = '0;
  logic [GW-1:0] gout0, goe0, gout2, goe2;
  logic          irq0, irq2;

  ahb_gpio_slave_if if0();
  ahb_gpio_slave_if if2();

  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;
  logic [GW-1:0] cur_out, cur_oe;
  assign cur_ready = use2 ? if2.HREADYOUT : if0.HREADYOUT;
  assign cur_resp  = use2 ? if2.HRESP     : if0.HRESP;
  assign cur_rdata = use2 ? if2.HRDATA    : if0.HRDATA;
  assign cur_out   = use2 ? gout2 : gout0;
  assign cur_oe    = use2 ? goe2  : goe0;

  assign if0.HSEL = hsel & ~use2;
  assign if2.HSEL = hsel & use2;
  assign if0.HADDR = haddr;   assign if2.HADDR = haddr;
  assign if0.HTRANS = htrans; assign if2.HTRANS = htrans;
  assign if0.HWRITE = hwrite; assign if2.HWRITE = hwrite;
  assign if0.HSIZE = hsize;   assign if2.HSIZE = hsize;
  assign if0.HWDATA = hwdata; assign if2.HWDATA = hwdata;
  assign if0.HREADY = cur_ready;
  assign if2.HREADY = cur_ready;

  ahb_gpio_slave #(.GPIO_WIDTH(GW), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(if0),
    .gpio_in(gin0), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0)
  );

  ahb_gpio_slave #(.GPIO_WIDTH(GW), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESET(rst), .bus(if2),
    .gpio_in(gin2), .gpio_out(gout2), .gpio_oe(goe2), .irq(irq2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single transfer: address phase now, then data phase until HREADYOUT
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [3:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic rdy_first, output logic [1:0] resp_first,
                          output logic [1:0] resp_last, output int waits);
    hsel = 1'b1; htrans = TRANS_NONSEQ; hwrite = wr; haddr = addr; hsize = size;
    step(1);
    hsel = 1'b0; htrans = TRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_32; hwdata = wdata;
    rdy_first  = cur_ready;
    resp_first = cur_resp;
    waits = 0;
    while (!cur_ready && waits < LIM) begin
      step(1);
      waits++;
    end
    rdata     = cur_rdata;
    resp_last = cur_resp;
    step(1);
    hwdata = '0;
  endtask

  // Write followed by a pipelined read whose address overlaps the write data phase
  task automatic ahb_pair(input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic [31:0] raddr, output int w1, output int w2,
                          output logic [GW-1:0] out_pre, output logic [GW-1:0] oe_pre,
                          output logic [GW-1:0] out_post, output logic [GW-1:0] oe_post,
                          output logic [31:0] rdata, output logic [1:0] resp);
    hsel = 1'b1; htrans = TRANS_NONSEQ; hwrite = 1'b1; haddr = waddr; hsize = HSIZE_32;
    step(1);
    hwdata = wdata; hwrite = 1'b0; haddr = raddr;
    w1 = 0;
    while (!cur_ready && w1 < LIM) begin
      step(1);
      w1++;
    end
    out_pre = cur_out; oe_pre = cur_oe;
    step(1);
    hsel = 1'b0; htrans = TRANS_IDLE; hwdata = '0;
    out_post = cur_out; oe_post = cur_oe;
    w2 = 0;
    while (!cur_ready && w2 < LIM) begin
      step(1);
      w2++;
    end
    rdata = cur_rdata;
    resp  = cur_resp;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0]   rd;
    logic          rf;
    logic [1:0]    r1, r2;
    int            w, w1, w2;
    logic [GW-1:0] op, ep, oq, eq;

    // Reset values
    step(3);
    check_eq("rst_hreadyout", 32'(if0.HREADYOUT), 32'd1);
    check_eq("rst_hresp", 32'(if0.HRESP), 32'(HRESP_OKAY));
    check_eq("rst_hrdata", if0.HRDATA, 32'h0);
    check_eq("rst_gpio_out", 32'(gout0), 32'h0);
    check_eq("rst_gpio_oe", 32'(goe0), 32'h0);
    check_eq("rst_irq", 32'(irq0), 32'd0);
    check_eq("rst_hreadyout_ws2", 32'(if2.HREADYOUT), 32'd1);
    @(negedge clk) rst = 1'b0;
    step(1);

    // No wait states: write DATA_OUT then read it back-to-back
    use2 = 1'b0;
    ahb_pair(32'h2020_0000, 32'h0000_5555, 32'h2020_0000, w1, w2, op, ep, oq, eq, rd, r1);
    check_eq("ws0_wr_waits", 32'(w1), 32'd0);
    check_eq("ws0_gpio_out", 32'(oq), 32'h5555);
    check_eq("ws0_rd_waits", 32'(w2), 32'd0);
    check_eq("ws0_rd_data", rd, 32'h0000_5555);
    check_eq("ws0_rd_resp", 32'(r1), 32'(HRESP_OKAY));

    // BUSY with HSEL, and NONSEQ without HSEL: neither is a transfer
    hsel = 1'b1; htrans = TRANS_BUSY; hwrite = 1'b1; haddr = 32'h2020_0000;
    step(1);
    hsel = 1'b0; htrans = TRANS_NONSEQ; hwdata = 32'h0000_FFFF;
    step(1);
    check_eq("noacc_hreadyout", 32'(if0.HREADYOUT), 32'd1);
    check_eq("noacc_hresp", 32'(if0.HRESP), 32'(HRESP_OKAY));
    htrans = TRANS_IDLE; hwrite = 1'b0; hwdata = '0;
    step(2);
    check_eq("noacc_gpio_out", 32'(gout0), 32'h5555);

    // Two wait states: write DIR then read it back-to-back
    use2 = 1'b1;
    ahb_pair(32'h2020_0004, 32'h0000_FFFF, 32'h2020_0004, w1, w2, op, ep, oq, eq, rd, r1);
    check_eq("ws2_wr_waits", 32'(w1), 32'd2);
    check_eq("ws2_oe_before", 32'(ep), 32'h0);
    check_eq("ws2_oe_after", 32'(eq), 32'hFFFF);
    check_eq("ws2_rd_waits", 32'(w2), 32'd2);
    check_eq("ws2_rd_data", rd, 32'h0000_FFFF);

    // Illegal accesses: ERROR for exactly two cycles, nothing written
    ahb_xfer(1'b1, 32'h2020_0001, HSIZE_32, 32'h1111, rd, rf, r1, r2, w);
    check_eq("mis_rdy_first", 32'(rf), 32'd0);
    check_eq("mis_resp_first", 32'(r1), 32'(HRESP_ERROR));
    check_eq("mis_cycles", 32'(w), 32'd1);
    check_eq("mis_resp_last", 32'(r2), 32'(HRESP_ERROR));
    ahb_xfer(1'b1, 32'h2020_0008, HSIZE_32, 32'h2222, rd, rf, r1, r2, w);
    check_eq("din_wr_rdy_first", 32'(rf), 32'd0);
    check_eq("din_wr_resp_first", 32'(r1), 32'(HRESP_ERROR));
    check_eq("din_wr_cycles", 32'(w), 32'd1);
    check_eq("din_wr_resp_last", 32'(r2), 32'(HRESP_ERROR));
    ahb_xfer(1'b1, 32'h2020_0000, HSIZE_8, 32'h3333, rd, rf, r1, r2, w);
    check_eq("byte_wr_resp", 32'(r2), 32'(HRESP_ERROR));
    check_eq("err_gpio_out", 32'(gout2), 32'h0);
    check_eq("err_gpio_oe", 32'(goe2), 32'hFFFF);

    // Input bit 3 rising: DATA_IN after 2 edges, IRQ one edge later
    use2 = 1'b0;
    gin0[3] = 1'b1;
    step(2);
    check_eq("irq_not_yet", 32'(irq0), 32'd0);
    step(1);
    check_eq("irq_set", 32'(irq0), 32'd1);
    ahb_xfer(1'b0, 32'h2020_0008, HSIZE_32, 32'h0, rd, rf, r1, r2, w);
    check_eq("din_read", rd, 32'h0000_0008);
    ahb_xfer(1'b0, 32'h2020_000C, HSIZE_32, 32'h0, rd, rf, r1, r2, w);
    check_eq("irqst_read", rd, 32'h0000_0008);
    ahb_xfer(1'b1, 32'h2020_000C, HSIZE_32, 32'h8, rd, rf, r1, r2, w);
    check_eq("irq_cleared", 32'(irq0), 32'd0);
    ahb_xfer(1'b0, 32'h2020_000C, HSIZE_32, 32'h0, rd, rf, r1, r2, w);
    check_eq("irqst_cleared", rd, 32'h0);

    // Rising edge on bit 0 in the same cycle as its W1C: set wins
    gin0[0] = 1'b1;
    step(1);
    ahb_xfer(1'b1, 32'h2020_000C, HSIZE_32, 32'h1, rd, rf, r1, r2, w);
    check_eq("coinc_irq", 32'(irq0), 32'd1);
    ahb_xfer(1'b0, 32'h2020_000C, HSIZE_32, 32'h0, rd, rf, r1, r2, w);
    check_eq("coinc_irqst", rd, 32'h0000_0001);

    // Reset during the wait states of a write aborts it
    use2 = 1'b1;
    ahb_xfer(1'b1, 32'h2020_0000, HSIZE_32, 32'h00AA, rd, rf, r1, r2, w);
    check_eq("pre_rst_gpio_out", 32'(gout2), 32'h00AA);
    hsel = 1'b1; htrans = TRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h2020_0000;
    step(1);
    hsel = 1'b0; htrans = TRANS_IDLE; hwrite = 1'b0; hwdata = 32'h1234;
    check_eq("mid_wait_hreadyout", 32'(if2.HREADYOUT), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_hreadyout", 32'(if2.HREADYOUT), 32'd1);
    check_eq("mid_rst_hresp", 32'(if2.HRESP), 32'(HRESP_OKAY));
    check_eq("mid_rst_gpio_out", 32'(gout2), 32'h0);
    @(negedge clk) rst = 1'b0;
    hwdata = '0;
    step(2);
    check_eq("post_rst_gpio_out", 32'(gout2), 32'h0);
    ahb_xfer(1'b0, 32'h2020_0000, HSIZE_32, 32'h0, rd, rf, r1, r2, w);
    check_eq("post_rst_rd_waits", 32'(w), 32'd2);
    check_eq("post_rst_rd_data", rd, 32'h0);
    check_eq("post_rst_rd_resp", 32'(r2), 32'(HRESP_OKAY));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
